// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller for the 5-stage RV32I core: merges redirects, load-use and cache
// status into per-stage hold/flush controls, the IF redirect and saturating perf counters.
module pipe_flow_ctrl #(
  parameter int          CNT_W  = 32,
  parameter logic [31:0] RST_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_jump_flag_i,
  input  logic [31:0]      id_jump_pc_i,
  input  logic             ex_btaken_i,
  input  logic [31:0]      ex_bpc_i,
  input  logic             id_load_use_flag_i,
  input  logic             icache_valid_i,
  input  logic             dcache_miss_i,
  input  logic             dcache_valid_i,
  output logic             fc_bk_if_o,
  output logic             fc_bk_id_o,
  output logic             fc_bk_ex_o,
  output logic             fc_flush_id_o,
  output logic             fc_flush_ex_o,
  output logic             fc_jump_flag_o,
  output logic [31:0]      fc_jump_pc_o,
  output logic             fc_Icache_data_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {RUN, LU, DSTALL, REDIR} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      st, st_nxt;
  logic        pend_vld, pend_vld_nxt;
  logic        pend_ex, pend_ex_nxt;
  logic [31:0] pend_pc, pend_pc_nxt;
  logic        bk_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= RUN;
      pend_vld <= 1'b0;
      pend_ex  <= 1'b0;
      pend_pc  <= RST_PC;
    end else begin
      st       <= st_nxt;
      pend_vld <= pend_vld_nxt;
      pend_ex  <= pend_ex_nxt;
      pend_pc  <= pend_pc_nxt;
    end
  end

  // Outputs are forced quiet while reset is held so nothing escapes before state is valid.
  always_comb begin
    st_nxt                 = st;
    pend_vld_nxt           = pend_vld;
    pend_ex_nxt            = pend_ex;
    pend_pc_nxt            = pend_pc;
    fc_bk_if_o             = 1'b0;
    fc_bk_id_o             = 1'b0;
    fc_bk_ex_o             = 1'b0;
    fc_flush_id_o          = 1'b0;
    fc_flush_ex_o          = 1'b0;
    fc_jump_flag_o         = 1'b0;
    fc_jump_pc_o           = RST_PC;
    fc_Icache_data_valid_o = 1'b0;
    if (rst_n) begin
      fc_Icache_data_valid_o = icache_valid_i;
      case (st)
        RUN: begin
          if (pend_vld) begin
            // Deferred redirect from a D-miss window goes out before anything new.
            fc_jump_flag_o         = 1'b1;
            fc_jump_pc_o           = pend_pc;
            fc_flush_id_o          = 1'b1;
            fc_flush_ex_o          = pend_ex;
            fc_Icache_data_valid_o = 1'b0;
            pend_vld_nxt           = 1'b0;
            pend_ex_nxt            = 1'b0;
            st_nxt                 = REDIR;
          end else if (ex_btaken_i) begin
            fc_jump_flag_o         = 1'b1;
            fc_jump_pc_o           = ex_bpc_i;
            fc_flush_id_o          = 1'b1;
            fc_flush_ex_o          = 1'b1;
            fc_Icache_data_valid_o = 1'b0;
            st_nxt                 = REDIR;
          end else if (id_jump_flag_i) begin
            fc_jump_flag_o         = 1'b1;
            fc_jump_pc_o           = id_jump_pc_i;
            fc_flush_id_o          = 1'b1;
            fc_Icache_data_valid_o = 1'b0;
            st_nxt                 = REDIR;
          end else if (dcache_miss_i) begin
            fc_bk_if_o = 1'b1;
            fc_bk_id_o = 1'b1;
            fc_bk_ex_o = 1'b1;
            st_nxt     = DSTALL;
          end else if (id_load_use_flag_i) begin
            fc_bk_if_o    = 1'b1;
            fc_bk_id_o    = 1'b1;
            fc_flush_ex_o = 1'b1;
            st_nxt        = LU;
          end else if (!icache_valid_i) begin
            fc_bk_if_o = 1'b1;
          end
        end
        LU: st_nxt = RUN;
        DSTALL: begin
          // An EX-sourced pending target is never displaced; ID only fills an empty slot.
          if (ex_btaken_i && !(pend_vld && pend_ex)) begin
            pend_vld_nxt = 1'b1;
            pend_ex_nxt  = 1'b1;
            pend_pc_nxt  = ex_bpc_i;
          end else if (id_jump_flag_i && !pend_vld) begin
            pend_vld_nxt = 1'b1;
            pend_ex_nxt  = 1'b0;
            pend_pc_nxt  = id_jump_pc_i;
          end
          if (dcache_valid_i) begin
            st_nxt = RUN;
          end else begin
            fc_bk_if_o = 1'b1;
            fc_bk_id_o = 1'b1;
            fc_bk_ex_o = 1'b1;
          end
        end
        REDIR: begin
          if (ex_btaken_i) begin
            fc_jump_flag_o         = 1'b1;
            fc_jump_pc_o           = ex_bpc_i;
            fc_flush_id_o          = 1'b1;
            fc_flush_ex_o          = 1'b1;
            fc_Icache_data_valid_o = 1'b0;
          end else if (icache_valid_i) begin
            st_nxt = RUN;
          end
        end
        default: st_nxt = RUN;
      endcase
    end
  end

  assign bk_any = fc_bk_if_o | fc_bk_id_o | fc_bk_ex_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (bk_any && !(&stall_cnt_o))         stall_cnt_o <= stall_cnt_o + CNT_ONE;
      if (fc_jump_flag_o && !(&flush_cnt_o)) flush_cnt_o <= flush_cnt_o + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed bench for pipe_flow_ctrl; narrow counters so saturation is reachable quickly.
module tb_pipe_flow_ctrl;
  localparam int          CNT_W  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0200;

  logic clk, rst_n;
  logic id_jump_flag, ex_btaken, load_use, icache_valid, dcache_miss, dcache_valid;
  logic [31:0] id_jump_pc, ex_bpc;
  logic bk_if, bk_id, bk_ex, flush_id, flush_ex, jump_flag, icv_o;
  logic [31:0] jump_pc;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  int n_chk, n_bad;

  pipe_flow_ctrl #(.CNT_W(CNT_W), .RST_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_jump_flag_i(id_jump_flag), .id_jump_pc_i(id_jump_pc),
    .ex_btaken_i(ex_btaken), .ex_bpc_i(ex_bpc),
    .id_load_use_flag_i(load_use), .icache_valid_i(icache_valid),
    .dcache_miss_i(dcache_miss), .dcache_valid_i(dcache_valid),
    .fc_bk_if_o(bk_if), .fc_bk_id_o(bk_id), .fc_bk_ex_o(bk_ex),
    .fc_flush_id_o(flush_id), .fc_flush_ex_o(flush_ex),
    .fc_jump_flag_o(jump_flag), .fc_jump_pc_o(jump_pc),
    .fc_Icache_data_valid_o(icv_o),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    id_jump_flag = 0; ex_btaken = 0; load_use = 0; icache_valid = 1;
    dcache_miss = 0; dcache_valid = 0; id_jump_pc = '0; ex_bpc = '0;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  // Reset with hostile inputs active: outputs must stay quiet until release.
  task automatic do_reset();
    idle();
    ex_btaken = 1; ex_bpc = 32'h999; dcache_miss = 1;
    rst_n = 0;
    #3;
    chk("rst_jump", jump_flag, 0);
    chk("rst_pc", jump_pc, RST_PC);
    chk("rst_bk", {bk_if, bk_id, bk_ex}, 0);
    chk("rst_flush", {flush_id, flush_ex}, 0);
    chk("rst_icv", icv_o, 0);
    chk("rst_cnt", {stall_cnt, flush_cnt}, 0);
    edge1();
    idle();
    rst_n = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 0; n_chk = 0; n_bad = 0;
    idle();
    rst_n = 0;
    do_reset();

    // EX branch in RUN
    ex_btaken = 1; ex_bpc = 32'h100;
    @(negedge clk);
    chk("ex_jump", jump_flag, 1);
    chk("ex_pc", jump_pc, 32'h100);
    chk("ex_flush", {flush_id, flush_ex}, 2'b11);
    chk("ex_bk", {bk_if, bk_id, bk_ex}, 0);
    chk("ex_icv", icv_o, 0);
    edge1(); ex_btaken = 0;
    chk("ex_fcnt", flush_cnt, 1);
    @(negedge clk);
    chk("redir_icv", icv_o, 1);
    chk("redir_nojump", jump_flag, 0);
    chk("redir_pc", jump_pc, RST_PC);
    edge1();

    // Load-use: one bubble, repeat in LU ignored
    do_reset();
    load_use = 1;
    @(negedge clk);
    chk("lu_bk", {bk_if, bk_id, bk_ex}, 3'b110);
    chk("lu_flush", {flush_id, flush_ex}, 2'b01);
    edge1();
    @(negedge clk);
    chk("lu2_bk", {bk_if, bk_id, bk_ex}, 0);
    chk("lu2_flush", {flush_id, flush_ex}, 0);
    edge1(); load_use = 0;
    chk("lu_scnt", stall_cnt, 1);

    // D-miss with ID jump deferred until after dcache_valid
    do_reset();
    dcache_miss = 1;
    @(negedge clk);
    chk("dm0_bk", {bk_if, bk_id, bk_ex}, 3'b111);
    edge1();
    for (int i = 1; i <= 5; i++) begin
      id_jump_flag = (i == 2); id_jump_pc = 32'h40;
      @(negedge clk);
      chk("dm_bk", {bk_if, bk_id, bk_ex}, 3'b111);
      chk("dm_nojump", jump_flag, 0);
      edge1();
    end
    id_jump_flag = 0; dcache_miss = 0; dcache_valid = 1;
    @(negedge clk);
    chk("dv_bk", {bk_if, bk_id, bk_ex}, 0);
    chk("dv_nojump", jump_flag, 0);
    edge1(); dcache_valid = 0;
    chk("dm_scnt", stall_cnt, 6);
    @(negedge clk);
    chk("pend_jump", jump_flag, 1);
    chk("pend_pc", jump_pc, 32'h40);
    chk("pend_flush", {flush_id, flush_ex}, 2'b10);
    chk("pend_bk", {bk_if, bk_id, bk_ex}, 0);
    edge1();
    chk("pend_fcnt", flush_cnt, 1);
    edge1();  // REDIR exits on icache_valid

    // EX pending beats a later ID jump
    dcache_miss = 1;
    edge1();
    ex_btaken = 1; ex_bpc = 32'h300;
    edge1();
    ex_btaken = 0; id_jump_flag = 1; id_jump_pc = 32'h44;
    edge1();
    id_jump_flag = 0; dcache_miss = 0; dcache_valid = 1;
    edge1(); dcache_valid = 0;
    @(negedge clk);
    chk("pex_pc", jump_pc, 32'h300);
    chk("pex_flush", {flush_id, flush_ex}, 2'b11);
    edge1();

    // Redirect with late icache_valid, ID jump ignored in REDIR
    do_reset();
    id_jump_flag = 1; id_jump_pc = 32'h80;
    @(negedge clk);
    chk("idj_jump", jump_flag, 1);
    chk("idj_pc", jump_pc, 32'h80);
    chk("idj_flush", {flush_id, flush_ex}, 2'b10);
    edge1();
    id_jump_flag = 0; icache_valid = 0;
    for (int i = 0; i < 4; i++) begin
      id_jump_flag = (i == 1); id_jump_pc = 32'h90;
      @(negedge clk);
      chk("rd_icv", icv_o, 0);
      chk("rd_nojump", jump_flag, 0);
      chk("rd_bk", bk_if, 0);
      edge1();
    end
    id_jump_flag = 0; icache_valid = 1;
    @(negedge clk);
    chk("rd5_icv", icv_o, 1);
    edge1();
    icache_valid = 0;
    @(negedge clk);
    chk("imiss_bk", {bk_if, bk_id, bk_ex}, 3'b100);
    edge1();
    icache_valid = 1; id_jump_flag = 1; id_jump_pc = 32'h80;
    edge1();
    id_jump_flag = 0; icache_valid = 0; ex_btaken = 1; ex_bpc = 32'h240;
    @(negedge clk);
    chk("rr_jump", jump_flag, 1);
    chk("rr_pc", jump_pc, 32'h240);
    chk("rr_flush", {flush_id, flush_ex}, 2'b11);
    edge1();
    ex_btaken = 0; icache_valid = 1;
    chk("rr_fcnt", flush_cnt, 3);

    // Redirect beats simultaneous D-miss
    do_reset();
    ex_btaken = 1; ex_bpc = 32'h500; dcache_miss = 1;
    @(negedge clk);
    chk("exdm_jump", jump_flag, 1);
    chk("exdm_bk", {bk_if, bk_id, bk_ex}, 0);
    edge1();

    // Counter saturation and async reset mid-DSTALL
    do_reset();
    dcache_miss = 1;
    for (int i = 0; i < 14; i++) edge1();
    chk("sat14", stall_cnt, 14);
    id_jump_flag = 1; id_jump_pc = 32'h70;
    for (int i = 0; i < 6; i++) edge1();
    chk("sat_hold", stall_cnt, 15);
    #2; rst_n = 0; #1;
    chk("arst_bk", {bk_if, bk_id, bk_ex}, 0);
    chk("arst_scnt", stall_cnt, 0);
    edge1();
    idle();
    rst_n = 1;
    @(negedge clk);
    chk("arst_nopend", jump_flag, 0);
    chk("arst_pc", jump_pc, RST_PC);
    edge1();
    chk("arst_fcnt", flush_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
